div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 divider for the RV64 M-extension: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
//  Sits beside the ALU in the execute stage and takes the same 5-bit control encoding space.
//  Uses a valid/ready handshake and a flush input. The pipeline stalls on !ready_o or on a pending result.
//  Division by zero and signed overflow are resolved on a fast path without iterating.
// PARAMETERS
//  DATA_WIDTH    64  operand/result width; iteration count for full-width ops
//  WORD_WIDTH    32  width of *W ops; iteration count for *W ops
//  CONTROL_WIDTH 5   width of op_i
// PORTS
//  clk_i     in   1              clock, all state updates on rising edge
//  rst_i     in   1              synchronous, active-high reset
//  valid_i   in   1              request valid
//  ready_o   out  1              unit can accept a request (high only in IDLE)
//  op_i      in   CONTROL_WIDTH  DIV=10011 DIVU=10100 REM=10101 REMU=10110 DIVW=11000 DIVUW=11001 REMW=11010 REMUW=11011
//  src_1_i   in   DATA_WIDTH     dividend
//  src_2_i   in   DATA_WIDTH     divisor
//  flush_i   in   1              kill the in-flight or pending operation
//  valid_o   out  1              result_o valid; held until ready_i
//  ready_i   in   1              consumer accepts result
//  result_o  out  DATA_WIDTH     registered quotient or remainder
// BEHAVIOUR
//  - Reset: state=IDLE, valid_o=0, result_o=0, all internal registers 0. ready_o=1 in the first cycle after reset.
//  - FSM states: IDLE, CALC, DONE. ready_o = (state==IDLE), combinational. valid_o = (state==DONE).
//  - IDLE->CALC on valid_i && ready_o && !flush_i. Op, sign flags and operand magnitudes are latched.
//    Iteration counter N is set to DATA_WIDTH, or to WORD_WIDTH for *W ops.
//  - IDLE->DONE on acceptance when the fast path applies:
//    - divisor==0: quotient = all ones; remainder = dividend.
//    - signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
//    - op_i not in the list above: result 0.
//  - Fast path latency: accept in cycle k, valid_o in cycle k+1.
//  - CALC: one restoring step per cycle.
//    - rem = {rem, quo[msb]} - divisor if non-negative, else keep; the quotient bit is shifted in.
//    - Exits to DONE after N steps. Accept in cycle k -> valid_o in cycle k+N+1 (65 for DIV, 33 for DIVW).
//  - Signed ops divide magnitudes, then negate: quotient if the operand signs differ, remainder if the dividend is negative.
//    The remainder sign follows the dividend. Sign fix-up and selection are applied when result_o is registered on CALC->DONE.
//  - *W ops:
//    - Operands are the low WORD_WIDTH bits: sign-extended for DIVW/REMW, zero-extended for DIVUW/REMUW.
//    - The result is always sign-extended from bit 31, including for DIVUW and REMUW.
//    - DIVW by 0 -> 0xFFFFFFFF_FFFFFFFF. REMUW by 0 -> sign-extended low word of the dividend.
//  - DONE: result_o and valid_o are held stable until ready_i. DONE->IDLE on ready_i. No request is accepted in DONE.
//  - flush_i, any state: next state IDLE, valid_o=0, no result produced.
//    flush_i has priority over valid_i and ready_i in the same cycle. A request presented with flush_i is not accepted.
//  - rst_i mid-CALC or in DONE: the same as reset. The partial result is discarded and ready_o=1 the next cycle.
//  - Throughput: one op per N+2 cycles when ready_i is tied high. One op per 2 cycles on the fast path.
// TESTING
//  - DIVU 100/7 -> result_o=14, valid_o exactly 65 cycles after accept.
//    REMU 100/7 -> 2. REM -7/2 -> -1. DIV -7/2 -> -3.
//  - DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF and REM 5/0 -> 5, each valid 1 cycle after accept.
//    DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same -> 0.
//  - DIVW src_1=0x1_8000_0000, src_2=-1 -> 0xFFFF_FFFF_8000_0000.
//    DIVUW 0xFFFF_FFFF/1 -> 0xFFFF_FFFF_FFFF_FFFF in 33 cycles. REMW -9/4 -> -1.
//  - Backpressure: ready_i low for 10 cycles in DONE -> result_o and valid_o stable, ready_o low, new valid_i ignored.
//    Then a ready_i pulse -> IDLE next cycle.
//  - flush_i at CALC step 20 -> valid_o never rises; ready_o=1 next cycle.
//    flush_i with valid_i in IDLE -> not accepted.
//  - rst_i asserted in CALC and in DONE -> valid_o=0, result_o=0, ready_o=1 next cycle.
//    Random signed/unsigned/W ops checked against a reference model, including +-1, 0 and min/max operands.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the *W forms.
// Division by zero, signed overflow and unknown ops take a one-cycle fast path.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a request; ready_o high
// S_CALC | one restoring step per cycle, cnt_q counts steps remaining
// S_DONE | result_o/valid_o held until ready_i
module div_unit #(
  parameter int DATA_WIDTH    = 64,
  parameter int WORD_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [CONTROL_WIDTH-1:0] op_i,
  input  logic [DATA_WIDTH-1:0]    src_1_i,
  input  logic [DATA_WIDTH-1:0]    src_2_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [DATA_WIDTH-1:0]    result_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int EXT_W = DATA_WIDTH - WORD_WIDTH;

  localparam logic [CONTROL_WIDTH-1:0] OP_DIV   = CONTROL_WIDTH'(5'b10011);
  localparam logic [CONTROL_WIDTH-1:0] OP_DIVU  = CONTROL_WIDTH'(5'b10100);
  localparam logic [CONTROL_WIDTH-1:0] OP_REM   = CONTROL_WIDTH'(5'b10101);
  localparam logic [CONTROL_WIDTH-1:0] OP_REMU  = CONTROL_WIDTH'(5'b10110);
  localparam logic [CONTROL_WIDTH-1:0] OP_DIVW  = CONTROL_WIDTH'(5'b11000);
  localparam logic [CONTROL_WIDTH-1:0] OP_DIVUW = CONTROL_WIDTH'(5'b11001);
  localparam logic [CONTROL_WIDTH-1:0] OP_REMW  = CONTROL_WIDTH'(5'b11010);
  localparam logic [CONTROL_WIDTH-1:0] OP_REMUW = CONTROL_WIDTH'(5'b11011);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] sext_word(input logic [WORD_WIDTH-1:0] x);
    return {{EXT_W{x[WORD_WIDTH-1]}}, x};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zext_word(input logic [WORD_WIDTH-1:0] x);
    return {{EXT_W{1'b0}}, x};
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0]  quo_q, quo_d;
  logic [DATA_WIDTH-1:0]  div_q, div_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   is_rem_q, is_rem_d;
  logic                   is_word_q, is_word_d;
  logic                   neg_quo_q, neg_quo_d;
  logic                   neg_rem_q, neg_rem_d;

  logic                   op_valid, op_signed, op_word, op_rem;
  logic [DATA_WIDTH-1:0]  a_eff, b_eff, a_mag, b_mag, min_val;
  logic                   a_neg, b_neg, div_zero, ovf, fast;
  logic [DATA_WIDTH-1:0]  fast_raw, fast_res;
  logic [DATA_WIDTH:0]    shifted, diff;
  logic                   step_ok, final_neg;
  logic [DATA_WIDTH-1:0]  rem_step, quo_step, final_raw, final_signed, final_res;

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;

  // Decode the op into signedness, word width and quotient/remainder select.
  always_comb begin
    op_valid  = 1'b1;
    op_signed = 1'b0;
    op_word   = 1'b0;
    op_rem    = 1'b0;
    case (op_i)
      OP_DIV:   op_signed = 1'b1;
      OP_DIVU:  ;
      OP_REM:   begin op_signed = 1'b1; op_rem = 1'b1; end
      OP_REMU:  op_rem = 1'b1;
      OP_DIVW:  begin op_signed = 1'b1; op_word = 1'b1; end
      OP_DIVUW: op_word = 1'b1;
      OP_REMW:  begin op_signed = 1'b1; op_word = 1'b1; op_rem = 1'b1; end
      OP_REMUW: begin op_word = 1'b1; op_rem = 1'b1; end
      default:  op_valid = 1'b0;
    endcase
  end

  // Extend word operands, take magnitudes and resolve the fast-path result.
  always_comb begin
    if (op_word) begin
      a_eff   = op_signed ? sext_word(src_1_i[WORD_WIDTH-1:0]) : zext_word(src_1_i[WORD_WIDTH-1:0]);
      b_eff   = op_signed ? sext_word(src_2_i[WORD_WIDTH-1:0]) : zext_word(src_2_i[WORD_WIDTH-1:0]);
      min_val = {{(EXT_W + 1){1'b1}}, {(WORD_WIDTH - 1){1'b0}}};
    end else begin
      a_eff   = src_1_i;
      b_eff   = src_2_i;
      min_val = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end
    a_neg    = op_signed & a_eff[DATA_WIDTH-1];
    b_neg    = op_signed & b_eff[DATA_WIDTH-1];
    a_mag    = a_neg ? -a_eff : a_eff;
    b_mag    = b_neg ? -b_eff : b_eff;
    div_zero = (b_eff == '0);
    ovf      = op_signed & (a_eff == min_val) & (b_eff == '1);
    fast     = !op_valid | div_zero | ovf;
    if (!op_valid) begin
      fast_raw = '0;
    end else if (div_zero) begin
      fast_raw = op_rem ? a_eff : '1;
    end else begin
      fast_raw = op_rem ? '0 : a_eff;
    end
    fast_res = op_word ? sext_word(fast_raw[WORD_WIDTH-1:0]) : fast_raw;
  end

  // One restoring step, plus the sign fix-up applied on the final step.
  always_comb begin
    shifted      = {rem_q, quo_q[DATA_WIDTH-1]};
    diff         = shifted - {1'b0, div_q};
    step_ok      = !diff[DATA_WIDTH];
    rem_step     = step_ok ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    quo_step     = {quo_q[DATA_WIDTH-2:0], step_ok};
    final_raw    = is_rem_q ? rem_step : quo_step;
    final_neg    = is_rem_q ? neg_rem_q : neg_quo_q;
    final_signed = final_neg ? -final_raw : final_raw;
    final_res    = is_word_q ? sext_word(final_signed[WORD_WIDTH-1:0]) : final_signed;
  end

  // Next-state and datapath update; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    result_d  = result_q;
    is_rem_d  = is_rem_q;
    is_word_d = is_word_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i && !flush_i) begin
          is_rem_d  = op_rem;
          is_word_d = op_word;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (fast) begin
            result_d = fast_res;
            state_d  = S_DONE;
          end else begin
            rem_d   = '0;
            // Word dividends are left-aligned so the step always consumes from the msb.
            quo_d   = op_word ? (a_mag << EXT_W) : a_mag;
            div_d   = b_mag;
            cnt_d   = op_word ? CNT_W'(WORD_WIDTH) : CNT_W'(DATA_WIDTH);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = final_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      is_word_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      result_q  <= result_d;
      is_rem_q  <= is_rem_d;
      is_word_q <= is_word_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomised checks of div_unit against hand values and a behavioural model.
module tb_div_unit;

  localparam logic [4:0] DIV   = 5'b10011;
  localparam logic [4:0] DIVU  = 5'b10100;
  localparam logic [4:0] REM   = 5'b10101;
  localparam logic [4:0] REMU  = 5'b10110;
  localparam logic [4:0] DIVW  = 5'b11000;
  localparam logic [4:0] DIVUW = 5'b11001;
  localparam logic [4:0] REMW  = 5'b11010;
  localparam logic [4:0] REMUW = 5'b11011;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [4:0]  op_i;
  logic [63:0] src_1_i, src_2_i, result_o;

  int errors = 0;
  int checks = 0;

  div_unit dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .src_1_i  (src_1_i),
    .src_2_i  (src_2_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [63:0] ref_res(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa = a;
    logic signed [63:0] sb = b;
    logic signed [31:0] wa = a[31:0];
    logic signed [31:0] wb = b[31:0];
    logic [31:0] ua = a[31:0];
    logic [31:0] ub = b[31:0];
    logic ovf64 = (a == MIN64) && (b == ONES);
    logic ovf32 = (ua == 32'h8000_0000) && (ub == 32'hFFFF_FFFF);
    case (op)
      DIV:   return (b == 0) ? ONES : ovf64 ? a : 64'(sa / sb);
      DIVU:  return (b == 0) ? ONES : a / b;
      REM:   return (b == 0) ? a : ovf64 ? 64'd0 : 64'(sa % sb);
      REMU:  return (b == 0) ? a : a % b;
      DIVW:  return (ub == 0) ? ONES : ovf32 ? sx32(ua) : sx32(32'(wa / wb));
      DIVUW: return (ub == 0) ? ONES : sx32(ua / ub);
      REMW:  return (ub == 0) ? sx32(ua) : ovf32 ? 64'd0 : sx32(32'(wa % wb));
      REMUW: return (ub == 0) ? sx32(ua) : sx32(ua % ub);
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    logic is_w = (op == DIVW) || (op == DIVUW) || (op == REMW) || (op == REMUW);
    logic sgn  = (op == DIV) || (op == REM) || (op == DIVW) || (op == REMW);
    if (!(is_w || op == DIV || op == DIVU || op == REM || op == REMU)) return 1;
    if (is_w) begin
      if (b[31:0] == 0) return 1;
      if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (b == 0) return 1;
    if (sgn && a == MIN64 && b == ONES) return 1;
    return 65;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 9))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = ONES;
      3: v = MIN64;
      4: v = 64'h7FFF_FFFF_FFFF_FFFF;
      5: v = 64'h0000_0000_8000_0000;
      6: v = 64'h0000_0000_7FFF_FFFF;
      7: v = {32'd0, 32'($urandom_range(0, 1000))};
      8: v = {32'hFFFF_FFFF, $urandom};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Present one request, wait (bounded) for valid_o, report result and latency.
  task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
    @(negedge clk_i);
    op_i = op; src_1_i = a; src_2_i = b; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    check("valid_timeout", 64'(valid_o), 64'd1);
    res = result_o;
  endtask

  task automatic release_result();
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check("ready_after_release", 64'(ready_o), 64'd1);
  endtask

  task automatic do_dir(input string tag, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    logic [63:0] res;
    int lat;
    run_op(op, a, b, res, lat);
    check(tag, res, exp);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    release_result();
  endtask

  logic [4:0] op_tab [9] = '{DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW, 5'b00000};

  initial begin
    logic [63:0] res, ra, rb;
    logic [4:0]  rop;
    int lat;
    logic seen;

    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    op_i = '0; src_1_i = '0; src_2_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check("reset_ready", 64'(ready_o), 64'd1);
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_result", result_o, 64'd0);

    do_dir("divu_100_7", DIVU, 64'd100, 64'd7, 64'd14, 65);
    do_dir("remu_100_7", REMU, 64'd100, 64'd7, 64'd2, 65);
    do_dir("rem_m7_2",   REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65);
    do_dir("div_m7_2",   DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    do_dir("div_5_0",    DIV,  64'd5, 64'd0, ONES, 1);
    do_dir("rem_5_0",    REM,  64'd5, 64'd0, 64'd5, 1);
    do_dir("div_ovf",    DIV,  MIN64, ONES, MIN64, 1);
    do_dir("rem_ovf",    REM,  MIN64, ONES, 64'd0, 1);
    do_dir("divw_ovf",   DIVW, 64'h0000_0001_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1);
    do_dir("divuw_max_1", DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, 33);
    do_dir("remw_m9_4",  REMW, 64'hFFFF_FFFF_FFFF_FFF7, 64'd4, ONES, 33);
    do_dir("divw_by0",   DIVW, 64'd123, 64'h0000_0001_0000_0000, ONES, 1);
    do_dir("remuw_by0",  REMUW, 64'h1234_5678_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1);
    do_dir("bad_op",     5'b00000, 64'd9, 64'd3, 64'd0, 1);

    // Backpressure: result held while ready_i low, new requests ignored.
    run_op(DIV, 64'd5, 64'd0, res, lat);
    check("bp_first", res, ONES);
    op_i = REMU; src_1_i = 64'd9; src_2_i = 64'd0; valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("bp_result", result_o, ONES);
      check("bp_valid", 64'(valid_o), 64'd1);
      check("bp_ready", 64'(ready_o), 64'd0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check("bp_release_ready", 64'(ready_o), 64'd1);
    check("bp_release_valid", 64'(valid_o), 64'd0);

    // Flush at CALC step 20.
    @(negedge clk_i);
    op_i = DIV; src_1_i = 64'd1000; src_2_i = 64'd3; valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (19) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_calc_ready", 64'(ready_o), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk_i);
      seen = seen | valid_o;
    end
    check("flush_calc_no_valid", 64'(seen), 64'd0);

    // Flush together with a request in IDLE: nothing accepted.
    op_i = DIV; src_1_i = 64'd5; src_2_i = 64'd0; valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush_idle_ready", 64'(ready_o), 64'd1);
    check("flush_idle_valid", 64'(valid_o), 64'd0);
    @(negedge clk_i);
    check("flush_idle_valid2", 64'(valid_o), 64'd0);

    // Reset mid-CALC (result_o currently holds a nonzero value).
    do_dir("pre_rst", REM, 64'd5, 64'd0, 64'd5, 1);
    op_i = DIVU; src_1_i = 64'd100; src_2_i = 64'd7; valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_calc_valid", 64'(valid_o), 64'd0);
    check("rst_calc_result", result_o, 64'd0);
    check("rst_calc_ready", 64'(ready_o), 64'd1);

    // Reset in DONE.
    run_op(DIV, 64'd5, 64'd0, res, lat);
    check("pre_rst_done", res, ONES);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_done_valid", 64'(valid_o), 64'd0);
    check("rst_done_result", result_o, 64'd0);
    check("rst_done_ready", 64'(ready_o), 64'd1);

    // Random ops against the behavioural model.
    for (int i = 0; i < 40; i++) begin
      rop = op_tab[$urandom_range(0, 8)];
      ra = pick();
      rb = pick();
      run_op(rop, ra, rb, res, lat);
      check("rand_result", res, ref_res(rop, ra, rb));
      check("rand_lat", 64'(lat), 64'(ref_lat(rop, ra, rb)));
      release_result();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
